// File: rtl/xbtn_responder.sv
// rtl/xbtn_responder.sv - memory-mapped debounced push-button responder
// Sticky press flags, press counter and level interrupt, polled over the sel/we/addr bus.
module xbtn_responder #(
    parameter int BTN_N      = 4,
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      data_in,
    output logic [31:0]      data_out,
    input  logic [BTN_N-1:0] btn_raw,
    output logic             irq
);

    localparam logic [1:0]       ADDR_STATUS  = 2'd0;
    localparam logic [1:0]       ADDR_PENDING = 2'd1;
    localparam logic [1:0]       ADDR_IRQ_EN  = 2'd2;
    localparam logic [1:0]       ADDR_COUNT   = 2'd3;
    localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEB_CYCLES - 1);

    logic [BTN_N-1:0] r_sync1;
    logic [BTN_N-1:0] r_sync2;
    logic [CNT_W-1:0] r_cnt [BTN_N];
    logic [BTN_N-1:0] r_stable;
    logic [BTN_N-1:0] r_pending;
    logic [BTN_N-1:0] r_irq_en;
    logic [15:0]      r_press_cnt;
    logic             r_irq;

    logic [BTN_N-1:0] w_diff;
    logic [BTN_N-1:0] w_accept;
    logic [BTN_N-1:0] w_press;
    logic [15:0]      w_popcnt;
    logic             w_rd;
    logic             w_wr;
    logic [BTN_N-1:0] w_pend_clr;
    logic             w_unused_data;

    assign w_unused_data = ^data_in[31:BTN_N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // A bit is accepted once it has differed from the stable level for DEB_CYCLES
    // consecutive cycles; any return to the stable level restarts the count.
    always_comb begin
        w_diff   = r_sync2 ^ r_stable;
        w_accept = '0;
        for (int i = 0; i < BTN_N; i++) begin
            w_accept[i] = w_diff[i] && (r_cnt[i] == DEB_LAST);
        end
        w_press = w_accept & r_sync2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTN_N; i++) begin
                r_cnt[i] <= '0;
            end
            r_stable <= '0;
        end else begin
            for (int i = 0; i < BTN_N; i++) begin
                if (!w_diff[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
            r_stable <= r_stable ^ w_accept;
        end
    end

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < BTN_N; i++) begin
            w_popcnt = w_popcnt + 16'(w_press[i]);
        end
    end

    assign w_rd = sel && !we;
    assign w_wr = sel && we;

    always_comb begin
        w_pend_clr = '0;
        if (w_rd && (addr == ADDR_PENDING)) begin
            w_pend_clr = '1;
        end else if (w_wr && (addr == ADDR_PENDING)) begin
            w_pend_clr = data_in[BTN_N-1:0];
        end
    end

    // New presses are OR-ed in after the clear so a coincident event is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending   <= '0;
            r_irq_en    <= '0;
            r_press_cnt <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_pend_clr) | w_press;
            if (w_wr && (addr == ADDR_IRQ_EN)) begin
                r_irq_en <= data_in[BTN_N-1:0];
            end
            if (w_wr && (addr == ADDR_COUNT)) begin
                r_press_cnt <= w_popcnt;
            end else begin
                r_press_cnt <= r_press_cnt + w_popcnt;
            end
            r_irq <= |(r_pending & r_irq_en);
        end
    end

    assign irq = r_irq;

    always_comb begin
        data_out = '0;
        if (sel) begin
            case (addr)
                ADDR_STATUS:  data_out = 32'(r_stable);
                ADDR_PENDING: data_out = 32'(r_pending);
                ADDR_IRQ_EN:  data_out = 32'(r_irq_en);
                ADDR_COUNT:   data_out = {16'b0, r_press_cnt};
                default:      data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_xbtn_responder.sv
// tb/tb_xbtn_responder.sv - directed self-checking bench for xbtn_responder
// Small debounce window (DEB_CYCLES=4) so every case fits in a few dozen cycles.
module tb_xbtn_responder;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [3:0]  btn_raw;
    logic        irq;

    int vectors;
    int miscompares;
    logic [31:0] rdata;

    xbtn_responder #(
        .BTN_N      (4),
        .DEB_CYCLES (4),
        .CNT_W      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .btn_raw  (btn_raw),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Combinational read with sel dropped before the next edge: no side effects.
    task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] exp);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        check(tag, data_out, exp);
        sel  = 1'b0;
        #1;
    endtask

    // Full one-cycle bus read; side effects land on the edge that ends it.
    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        check(tag, data_out, exp);
        tick(1);
        sel  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel     = 1'b1;
        we      = 1'b1;
        addr    = a;
        data_in = d;
        tick(1);
        sel     = 1'b0;
        we      = 1'b0;
        data_in = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        sel         = 1'b0;
        we          = 1'b0;
        addr        = '0;
        data_in     = '0;
        btn_raw     = '0;
        tick(3);
        rst = 1'b0;

        // 1. reset state
        peek("rst_status", 2'd0, 32'h0);
        peek("rst_pending", 2'd1, 32'h0);
        peek("rst_irq_en", 2'd2, 32'h0);
        peek("rst_count", 2'd3, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        // 2. clean press on btn1: stable exactly 6 edges after the change
        btn_raw[1] = 1'b1;
        tick(5);
        peek("press1_status_early", 2'd0, 32'h0);
        tick(1);
        peek("press1_status", 2'd0, 32'h2);
        check("sel0_data_out", data_out, 32'h0);
        rd("press1_pending", 2'd1, 32'h2);
        rd("press1_count", 2'd3, 32'h1);
        rd("press1_pending_again", 2'd1, 32'h0);
        check("press1_irq_disabled", {31'b0, irq}, 32'h0);
        btn_raw[1] = 1'b0;
        tick(8);
        peek("release1_status", 2'd0, 32'h0);
        peek("release1_pending", 2'd1, 32'h0);
        wr(2'd3, 32'hDEAD_BEEF);
        peek("count_cleared", 2'd3, 32'h0);

        // 3. 3-cycle glitch on btn0 is rejected
        btn_raw[0] = 1'b1;
        tick(3);
        btn_raw[0] = 1'b0;
        tick(10);
        peek("glitch_status", 2'd0, 32'h0);
        peek("glitch_pending", 2'd1, 32'h0);
        peek("glitch_count", 2'd3, 32'h0);

        // 4. interrupt on btn0, cleared by W1C
        wr(2'd2, 32'h1);
        peek("irq_en_rb", 2'd2, 32'h1);
        btn_raw[0] = 1'b1;
        tick(6);
        peek("btn0_pending", 2'd1, 32'h1);
        check("irq_not_yet", {31'b0, irq}, 32'h0);
        tick(1);
        check("irq_rise", {31'b0, irq}, 32'h1);
        wr(2'd0, 32'hF);
        peek("status_wr_ignored", 2'd0, 32'h1);
        wr(2'd1, 32'h0);
        peek("w1c_zero_nochange", 2'd1, 32'h1);
        wr(2'd1, 32'h1);
        peek("w1c_cleared", 2'd1, 32'h0);
        check("irq_still_high", {31'b0, irq}, 32'h1);
        tick(1);
        check("irq_fall", {31'b0, irq}, 32'h0);
        btn_raw[0] = 1'b0;
        tick(8);

        // 5. press of btn2 coincides with a PENDING read: set wins
        btn_raw[2] = 1'b1;
        tick(5);
        rd("race_read_old", 2'd1, 32'h0);
        peek("race_bit_kept", 2'd1, 32'h4);
        tick(1);
        check("irq_masked_bit2", {31'b0, irq}, 32'h0);
        rd("race_read_new", 2'd1, 32'h4);
        rd("race_read_cleared", 2'd1, 32'h0);
        peek("count_two", 2'd3, 32'h2);

        // 6. counter wrap, COUNT write racing a press, then reset mid-debounce
        force dut.r_press_cnt = 16'hFFFF;
        tick(1);
        release dut.r_press_cnt;
        peek("count_preload", 2'd3, 32'h0000_FFFF);
        btn_raw[3] = 1'b1;
        tick(6);
        peek("count_wrap", 2'd3, 32'h0);
        btn_raw[1] = 1'b1;
        tick(5);
        wr(2'd3, 32'h1234);
        peek("count_wr_race", 2'd3, 32'h1);
        peek("pending_3_1", 2'd1, 32'hA);
        wr(2'd2, 32'hF);
        tick(1);
        check("irq_all_en", {31'b0, irq}, 32'h1);
        btn_raw[0] = 1'b1;
        tick(3);
        rst = 1'b1;
        #1;
        check("rst_async_irq", {31'b0, irq}, 32'h0);
        peek("midrst_status", 2'd0, 32'h0);
        peek("midrst_pending", 2'd1, 32'h0);
        peek("midrst_irq_en", 2'd2, 32'h0);
        peek("midrst_count", 2'd3, 32'h0);
        tick(2);
        rst = 1'b0;
        tick(5);
        peek("held_status_early", 2'd0, 32'h0);
        tick(1);
        peek("held_status", 2'd0, 32'hF);
        peek("held_pending", 2'd1, 32'hF);
        peek("held_count", 2'd3, 32'h4);
        tick(1);
        check("held_irq_off", {31'b0, irq}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
